// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the frame.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    localparam logic TX_IDLE   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: bit_tick pulses every CLKS_PER_BIT cycles after clear drops.
// tick_next predicts bit_tick one cycle ahead.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick,
    output logic tick_next
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = r_cnt + CW'(1);
        if (clear || (r_cnt == LAST)) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign bit_tick  = !clear && (r_cnt == LAST);
    assign tick_next = (w_cnt_next == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO and serialises them as start, LSB-first data, [parity], stop.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_r_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);
    import fifo_uart_tx_pkg::*;

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_e            r_state, w_state_next;
    logic              r_tx, w_tx_next;
    logic              r_rd_en, w_rd_en_next;
    logic              r_busy, w_busy_next;
    logic              r_frame_done, w_frame_done_next;
    logic [DATA_W-1:0] r_shift, w_shift_next;
    logic [BW-1:0]     r_bit_cnt, w_bit_cnt_next;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              r_parity, w_parity_next;
`endif

    logic w_timer_clear;
    logic w_bit_tick;
    logic w_tick_next;

    // Timer is held cleared until the first START cycle so every bit gets a full period.
    assign w_timer_clear = (r_state == IDLE) || (r_state == POP) || (r_state == LOAD);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_timer_clear),
        .bit_tick (w_bit_tick),
        .tick_next(w_tick_next)
    );

    always_comb begin
        w_state_next   = r_state;
        w_tx_next      = r_tx;
        w_rd_en_next   = 1'b0;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
`ifdef FIFO_UART_TX_PARITY_EN
        w_parity_next  = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_tx_next = TX_IDLE;
                if (!fifo_empty) begin
                    w_rd_en_next = 1'b1;
                    w_state_next = POP;
                end
            end
            POP: begin
                w_state_next = LOAD;
            end
            LOAD: begin
                w_shift_next  = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                w_parity_next = ^fifo_data;
`endif
                w_tx_next     = START_BIT;
                w_state_next  = START;
            end
            START: begin
                if (w_bit_tick) begin
                    w_tx_next      = r_shift[0];
                    w_bit_cnt_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        w_tx_next    = r_parity;
                        w_state_next = PARITY;
`else
                        w_tx_next    = STOP_BIT;
                        w_state_next = STOP;
`endif
                    end else begin
                        w_shift_next   = r_shift >> 1;
                        w_tx_next      = w_shift_next[0];
                        w_bit_cnt_next = r_bit_cnt + BW'(1);
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_tick) begin
                    w_tx_next    = STOP_BIT;
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_bit_tick) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = TX_IDLE;
            end
        endcase

        // Registered pulse lands on the final stop-bit cycle itself.
        w_frame_done_next = (w_state_next == STOP) && w_tick_next;
        w_busy_next       = (w_state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tx         <= TX_IDLE;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_tx         <= w_tx_next;
            r_rd_en      <= w_rd_en_next;
            r_busy       <= w_busy_next;
            r_frame_done <= w_frame_done_next;
            r_shift      <= w_shift_next;
            r_bit_cnt    <= w_bit_cnt_next;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity     <= w_parity_next;
`endif
        end
    end

    assign fifo_r_en  = r_rd_en;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
